shift_register_sipo: RTL and testbench
======================================

Name: shift_register_sipo

Overview:
Serial-in parallel-out deserializer. It is the receive-side counterpart of the team's parallel-in serial-out shift register.
- Bits arrive LSB first, one per advance_i strobe.
- After WIDTH bits the assembled word moves into a one-entry output buffer and is presented on a valid/ready handshake.
- It sits at the receive end of any serial link fed by the PISO. It frames words with an internal bit counter and flags words lost to back-pressure.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
COVER, 0, for testing use only; set to 1 to include cover properties during formal verification.

Ports:
clk_i  input  1  system clock; all state changes on its rising edge.
rst_ni  input  1  asynchronous active-low reset; clears all state.
clear_i  input  1  synchronous flush; discards the partial word and the buffered word, and clears overflow_o.
bit_i  input  1  serial data bit; sampled only when advance_i=1.
advance_i  input  1  shift strobe; shifts bit_i into the assembly register.
value_o  output  WIDTH  buffered word; first-received bit at bit 0.
valid_o  output  1  value_o holds an unconsumed word.
ready_i  input  1  consumer accepts value_o when valid_o && ready_i.
overflow_o  output  1  sticky flag; a completed word was dropped.
count_o  output  CW  bits captured in the current partial word, 0..WIDTH-1; CW = $clog2(WIDTH).

Behaviour:
Reset:
- rst_ni=0 asynchronously clears the shift register, count_o, value_o, valid_o and overflow_o to 0.
- Release of reset is synchronous to clk_i.

Priority per edge: clear_i > advance_i > hold.

Shift:
- On advance_i=1 (and clear_i=0): shift <= {bit_i, shift[WIDTH-1:1]}.
- The bit enters at the MSB and moves right, so WIDTH strobes place the first bit at bit 0. This matches the PISO LSB-first order.

Counter:
- count increments on each advance.
- On the advance where count==WIDTH-1, count wraps to 0 and the word completes. The completed word is {bit_i, shift[WIDTH-1:1]}.
- The counter has no other wrap path.

Completion, decided per edge with pop = valid_o && ready_i:
- valid_o=0: buffer <= word; valid_o=1 after this edge (latency 1 cycle from the last bit).
- valid_o=1 and pop=1: buffer <= new word; valid_o stays 1. There is no bubble and no loss.
- valid_o=1 and pop=0: new word is dropped; buffer and valid_o are unchanged; overflow_o <= 1.

Pop without completion:
- valid_o <= 0 on the next edge. value_o keeps its last value but is don't-care.

Output stability:
- value_o and valid_o change only on a completion or a pop; they are stable while valid_o=1 && ready_i=0.
- ready_i is ignored while valid_o=0.

overflow_o:
- Sticky; cleared only by clear_i or reset.
- Setting it does not disturb valid_o or value_o.

clear_i=1:
- Next edge: shift, count, valid_o and overflow_o go to 0.
- Any advance_i or pop in the same cycle is ignored; a word completing that cycle is discarded.

Other boundaries:
- advance_i=0: all state holds, including the partial word, indefinitely.
- Reset asserted mid-word or while valid_o=1: the word is lost and there is no residual state.

Formal (COVER=1):
- Asserts: count_o < WIDTH; valid_o/value_o stable while not popped; overflow_o never falls without clear_i.
- Covers: first completion; back-to-back completion with a pop; overflow.

Test Plan:
1. WIDTH=8, ready_i=0; advance bits 1,0,1,0,0,1,0,1 on consecutive cycles -> valid_o=1 the cycle after the 8th edge, value_o=8'hA5, count_o=0, overflow_o=0.
2. ready_i held 1; stream 8'h3C then 8'hC3 with no gaps -> two single-cycle valid_o pulses with value_o 8'h3C then 8'hC3; overflow_o stays 0.
3. ready_i=0; stream 8'h11 then 8'h22 -> value_o stays 8'h11, valid_o=1, overflow_o=1 after the 16th edge; then ready_i=1 for one cycle -> valid_o=0, overflow_o still 1.
4. Valid word 8'h11 held; the 8th bit of 8'h22 arrives in the same cycle as ready_i=1 -> valid_o stays 1, value_o=8'h22, overflow_o=0.
5. Advance 5 bits, pulse clear_i together with advance_i, then send 8'h5A -> count_o=0 after clear; the next valid_o shows 8'h5A, proving no stale bits.
6. Advance 3 bits with valid_o=1, then drop rst_ni asynchronously mid-cycle -> all outputs read 0 immediately, before the next clk_i edge; the following full word 8'hFF is received correctly.

Source files
------------

// File: rtl/shift_register_sipo.sv
// Serial-in parallel-out deserializer: LSB-first bits are framed into WIDTH-bit words.
// Each word is handed off through a one-entry valid/ready buffer; words that find the buffer full are dropped and flagged.
module shift_register_sipo #(
  parameter int WIDTH = 8,
  parameter bit COVER = 1'b0,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             bit_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] value_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overflow_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count_q;
  logic             valid_q;
  logic             ovf_q;
  logic             last;
  logic             complete;
  logic             pop;

  assign word     = {bit_i, shift_q[WIDTH-1:1]};
  assign last     = (count_q == CW'(WIDTH-1));
  assign complete = advance_i && last;
  assign pop      = valid_q && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      buf_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      // The buffered word is invalidated; its bits are don't-care once valid drops.
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (advance_i) begin
        shift_q <= word;
        count_q <= last ? '0 : count_q + 1'b1;
      end
      if (complete) begin
        // A pop in the same cycle frees the slot, so the new word lands with no bubble.
        if (!valid_q || pop) begin
          buf_q   <= word;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign value_o    = buf_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;
  assign count_o    = count_q;

  if (COVER) begin : g_formal
    a_count_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(count_o) < WIDTH);
    a_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_o && !ready_i && !clear_i |=> valid_o && $stable(value_o));
    a_ovf_sticky : assert property (@(posedge clk_i) disable iff (!rst_ni)
      overflow_o && !clear_i |=> overflow_o);
    c_first : cover property (@(posedge clk_i) disable iff (!rst_ni)
      !valid_o && complete && !clear_i);
    c_b2b : cover property (@(posedge clk_i) disable iff (!rst_ni)
      complete && pop && !clear_i);
    c_ovf : cover property (@(posedge clk_i) disable iff (!rst_ni)
      complete && valid_o && !ready_i && !clear_i);
  end

endmodule

// File: tb/tb_shift_register_sipo.sv
// Directed bench for shift_register_sipo: stimulus pushes expected accepted words,
// a negedge monitor pops and compares them on every valid/ready transfer.
module tb_shift_register_sipo;

  localparam int WIDTH = 8;
  localparam int CW = $clog2(WIDTH);

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic             bit_i = 1'b0;
  logic             advance_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [WIDTH-1:0] value_o;
  logic             valid_o;
  logic             overflow_o;
  logic [CW-1:0]    count_o;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_register_sipo #(.WIDTH(WIDTH), .COVER(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .bit_i(bit_i),
    .advance_i(advance_i), .value_o(value_o), .valid_o(valid_o),
    .ready_i(ready_i), .overflow_o(overflow_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the edge after a negedge that sees valid && ready.
  always @(negedge clk_i) begin
    if (rst_ni && !clear_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got 0x%0h expected no word", value_o);
      end else begin
        check("sb_word", 32'(value_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_i = b;
    advance_i = 1'b1;
    tick();
    advance_i = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
  endtask

  task automatic drain();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst_ni = 1'b0;
    tick();
    tick();
    check("rst_value", 32'(value_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_count", 32'(count_o), 0);
    rst_ni = 1'b1;
    tick();

    // 1: single word, consumer stalled
    exp_q.push_back(8'hA5);
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    send_bit(0); send_bit(1); send_bit(0);
    check("t1_count7", 32'(count_o), 7);
    check("t1_valid_early", 32'(valid_o), 0);
    send_bit(1);
    check("t1_valid", 32'(valid_o), 1);
    check("t1_value", 32'(value_o), 32'h A5);
    check("t1_count", 32'(count_o), 0);
    check("t1_ovf", 32'(overflow_o), 0);
    drain();
    check("t1_popped", 32'(valid_o), 0);

    // 2: back-to-back words with ready held high
    ready_i = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_word(8'h3C);
    check("t2_valid1", 32'(valid_o), 1);
    check("t2_value1", 32'(value_o), 32'h3C);
    send_bit(1);
    check("t2_pulse1", 32'(valid_o), 0);
    w = 8'hC3;
    for (int i = 1; i < WIDTH; i++) send_bit(w[i]);
    check("t2_value2", 32'(value_o), 32'hC3);
    tick();
    check("t2_pulse2", 32'(valid_o), 0);
    check("t2_ovf", 32'(overflow_o), 0);
    ready_i = 1'b0;

    // 3: overflow on a full buffer
    exp_q.push_back(8'h11);
    send_word(8'h11);
    send_word(8'h22);
    check("t3_value", 32'(value_o), 32'h11);
    check("t3_valid", 32'(valid_o), 1);
    check("t3_ovf", 32'(overflow_o), 1);
    drain();
    check("t3_popped", 32'(valid_o), 0);
    check("t3_ovf_sticky", 32'(overflow_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t3_ovf_clear", 32'(overflow_o), 0);

    // 4: completion coincident with a pop
    exp_q.push_back(8'h11);
    send_word(8'h11);
    w = 8'h22;
    for (int i = 0; i < WIDTH-1; i++) send_bit(w[i]);
    exp_q.push_back(8'h22);
    ready_i = 1'b1;
    send_bit(w[WIDTH-1]);
    ready_i = 1'b0;
    check("t4_valid", 32'(valid_o), 1);
    check("t4_value", 32'(value_o), 32'h22);
    check("t4_ovf", 32'(overflow_o), 0);
    drain();

    // 5: clear together with advance discards the partial word
    for (int i = 0; i < 5; i++) send_bit(1);
    check("t5_count5", 32'(count_o), 5);
    clear_i = 1'b1;
    send_bit(1);
    clear_i = 1'b0;
    check("t5_count_clr", 32'(count_o), 0);
    check("t5_valid_clr", 32'(valid_o), 0);
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    check("t5_valid", 32'(valid_o), 1);
    check("t5_value", 32'(value_o), 32'h5A);
    drain();

    // 6: async reset mid-word with a word buffered
    send_word(8'h77);
    send_bit(1); send_bit(0); send_bit(1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_value", 32'(value_o), 0);
    check("t6_valid", 32'(valid_o), 0);
    check("t6_ovf", 32'(overflow_o), 0);
    check("t6_count", 32'(count_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    exp_q.push_back(8'hFF);
    send_word(8'hFF);
    check("t6_valid_ff", 32'(valid_o), 1);
    check("t6_value_ff", 32'(value_o), 32'hFF);
    drain();
    tick();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
